// File: rtl/cpu_clk_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : cpu_clk_ctrl_if
// Description : Control and status bundle for the CPU clock controller.
//               Inputs from the front panel / CPU go controller-ward; the
//               enables, state and pulse count come back.
//   run_sw      : async run switch (raw)
//   step_btn    : async step button (raw, bouncy)
//   div_sel     : CPU speed select, 0 = slowest .. 3 = fastest
//   halt_req    : CPU halt request, clk_board domain
//   cpu_ce      : one-cycle CPU clock enable
//   led_ce      : one-cycle LED scan enable
//   state       : controller state (PAUSE/RUN/STEP/HALTED)
//   cycle_count : number of cpu_ce pulses issued, wraps at 2^32
// Revision    : 1.0 - initial release
// ============================================================================
interface cpu_clk_ctrl_if;
  logic        run_sw;
  logic        step_btn;
  logic [1:0]  div_sel;
  logic        halt_req;
  logic        cpu_ce;
  logic        led_ce;
  logic [1:0]  state;
  logic [31:0] cycle_count;

  // Panel / CPU side: drives the requests, observes the enables.
  modport master (
    output run_sw, step_btn, div_sel, halt_req,
    input  cpu_ce, led_ce, state, cycle_count
  );

  // Controller side.
  modport slave (
    input  run_sw, step_btn, div_sel, halt_req,
    output cpu_ce, led_ce, state, cycle_count
  );
endinterface
`default_nettype wire

// File: rtl/cpu_clk_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : cpu_clk_ctrl
// Description : Run/pause/single-step clock-enable generator for a hobby CPU.
//               Produces a divided CPU clock enable selected by div_sel, a
//               free-running LED scan enable, and a count of CPU ticks.
//               Everything runs on clk_board; no derived clocks.
// Ports       : clk_board - board clock (sole clock)
//               rst       - synchronous active-high reset
//               bus       - cpu_clk_ctrl_if.slave (requests in, enables out)
// Revision    : 1.0 - initial release
// ============================================================================
module cpu_clk_ctrl #(
  parameter int unsigned CPU_DIV0  = 5000000,
  parameter int unsigned CPU_DIV1  = 500000,
  parameter int unsigned CPU_DIV2  = 50000,
  parameter int unsigned CPU_DIV3  = 2,
  parameter int unsigned LED_DIV   = 50000,
  parameter int unsigned DB_CYCLES = 1000000
) (
  input  logic               clk_board,
  input  logic               rst,
  cpu_clk_ctrl_if.slave      bus
);

  typedef enum logic [1:0] {
    PAUSE  = 2'b00,
    RUN    = 2'b01,
    STEP   = 2'b10,
    HALTED = 2'b11
  } state_t;

  localparam logic [31:0] C_LED_LAST = 32'(LED_DIV - 1);
  localparam logic [31:0] C_DB_LAST  = 32'(DB_CYCLES - 1);

  // Synchronizers
  logic        r_run_s1, r_run_s2;
  logic        r_step_s1, r_step_s2;

  // Step debouncer and edge detect
  logic        r_db_level;
  logic [31:0] r_db_cnt;
  logic        r_db_prev;
  logic        r_step_pulse;

  // Divider / FSM
  logic [1:0]  r_div_sel;
  state_t      r_state, w_state_d;
  logic [31:0] r_cnt, w_cnt_d;
  logic [31:0] w_div_cur;
  logic        w_div_chg;
  logic        w_halt_take;
  logic        r_cpu_ce, w_cpu_ce_d;

  // LED scan and tick counter
  logic [31:0] r_led_cnt;
  logic        r_led_ce;
  logic [31:0] r_cycle_count;

  function automatic logic [31:0] div_of(input logic [1:0] sel);
    case (sel)
      2'd0:    div_of = 32'(CPU_DIV0);
      2'd1:    div_of = 32'(CPU_DIV1);
      2'd2:    div_of = 32'(CPU_DIV2);
      default: div_of = 32'(CPU_DIV3);
    endcase
  endfunction

  assign w_div_cur = div_of(r_div_sel);
  // div_sel is about to register a new value: the divider restarts from 0
  // on the same edge that the new divisor takes effect.
  assign w_div_chg = (bus.div_sel != r_div_sel);
  // halt_req only matters on a cycle that is actually clocking the CPU.
  assign w_halt_take = r_cpu_ce && bus.halt_req;

  // Next state, next divider count and next cpu_ce. cpu_ce is computed one
  // cycle ahead so the registered output lines up with the RUN cycle whose
  // count is N-1, and with the STEP cycle itself.
  always_comb begin
    w_state_d  = r_state;
    w_cnt_d    = '0;
    w_cpu_ce_d = 1'b0;

    case (r_state)
      PAUSE: begin
        if (r_run_s2)
          w_state_d = RUN;
        else if (r_step_pulse)
          w_state_d = STEP;
      end
      RUN: begin
        if (w_halt_take)
          w_state_d = HALTED;
        else if (!r_run_s2)
          w_state_d = PAUSE;
      end
      STEP: begin
        if (w_halt_take)
          w_state_d = HALTED;
        else
          w_state_d = PAUSE;
      end
      HALTED: begin
        w_state_d = HALTED;
      end
      default: begin
        w_state_d = PAUSE;
      end
    endcase

    // The count only advances while staying in RUN; entry into RUN, any
    // non-RUN cycle, a divisor change and the terminal count all give 0.
    if ((r_state == RUN) && (w_state_d == RUN) && !w_div_chg &&
        (r_cnt != (w_div_cur - 32'd1)))
      w_cnt_d = r_cnt + 32'd1;

    // With every divisor >= 2, a count of 0 never fires, so a pulse is
    // never followed by another on the next cycle.
    w_cpu_ce_d = (w_state_d == STEP) ||
                 ((w_state_d == RUN) && (w_cnt_d == (w_div_cur - 32'd1)));
  end

  always_ff @(posedge clk_board) begin
    if (rst) begin
      r_run_s1      <= 1'b0;
      r_run_s2      <= 1'b0;
      r_step_s1     <= 1'b0;
      r_step_s2     <= 1'b0;
      r_db_level    <= 1'b0;
      r_db_cnt      <= '0;
      r_db_prev     <= 1'b0;
      r_step_pulse  <= 1'b0;
      r_div_sel     <= 2'd0;
      r_state       <= PAUSE;
      r_cnt         <= '0;
      r_cpu_ce      <= 1'b0;
      r_led_cnt     <= '0;
      r_led_ce      <= 1'b0;
      r_cycle_count <= '0;
    end else begin
      r_run_s1  <= bus.run_sw;
      r_run_s2  <= r_run_s1;
      r_step_s1 <= bus.step_btn;
      r_step_s2 <= r_step_s1;

      // The debounced level follows only after DB_CYCLES consecutive
      // cycles of disagreement; any agreement restarts the window.
      if (r_step_s2 != r_db_level) begin
        if (r_db_cnt == C_DB_LAST) begin
          r_db_level <= r_step_s2;
          r_db_cnt   <= '0;
        end else begin
          r_db_cnt <= r_db_cnt + 32'd1;
        end
      end else begin
        r_db_cnt <= '0;
      end

      // Rising edge of the debounced level only; release is silent.
      r_db_prev    <= r_db_level;
      r_step_pulse <= r_db_level && !r_db_prev;

      r_div_sel <= bus.div_sel;
      r_state   <= w_state_d;
      r_cnt     <= w_cnt_d;
      r_cpu_ce  <= w_cpu_ce_d;

      if (r_led_cnt == C_LED_LAST) begin
        r_led_cnt <= '0;
        r_led_ce  <= 1'b1;
      end else begin
        r_led_cnt <= r_led_cnt + 32'd1;
        r_led_ce  <= 1'b0;
      end

      if (r_cpu_ce)
        r_cycle_count <= r_cycle_count + 32'd1;
    end
  end

  assign bus.cpu_ce      = r_cpu_ce;
  assign bus.led_ce      = r_led_ce;
  assign bus.state       = r_state;
  assign bus.cycle_count = r_cycle_count;

endmodule
`default_nettype wire

// File: doc/cpu_clk_ctrl.md
CPU_CLK_CTRL -- requirements
Module: cpu_clk_ctrl

Interface
REQ-001 SHALL have parameter CPU_DIV0, default 5000000, clk_board cycles per CPU tick when div_sel=0.
REQ-002 SHALL have parameter CPU_DIV1, default 500000, cycles per tick when div_sel=1.
REQ-003 SHALL have parameter CPU_DIV2, default 50000, cycles per tick when div_sel=2.
REQ-004 SHALL have parameter CPU_DIV3, default 2, cycles per tick when div_sel=3; every CPU_DIVn is at least 2.
REQ-005 SHALL have parameter LED_DIV, default 50000, cycles per LED scan tick, at least 2.
REQ-006 SHALL have parameter DB_CYCLES, default 1000000, step-button stability window, at least 1.
REQ-007 SHALL have ports: clk_board  in  1  board clock, sole clock; rst  in  1  synchronous active-high reset.
REQ-008 SHALL have ports: run_sw  in  1  async run switch; step_btn  in  1  async raw step button; div_sel  in  2  speed select; halt_req  in  1  CPU halt request, clk_board domain.
REQ-009 SHALL have ports: cpu_ce  out  1  one-cycle CPU clock enable; led_ce  out  1  one-cycle LED scan enable; state  out  2  controller state; cycle_count  out  32  number of cpu_ce pulses issued.

Function
REQ-010 SHALL use a single clock; all flops on posedge clk_board; no derived clocks.
REQ-011 SHALL pass run_sw and step_btn each through a 2-flop synchronizer before any use.
REQ-012 SHALL debounce synced step_btn: the debounced level takes the synced value once that value has differed from it for DB_CYCLES consecutive cycles; any reversion restarts the window.
REQ-013 SHALL generate an internal step pulse, one cycle wide, on the cycle after a debounced 0->1 transition; a debounced 1->0 transition generates no pulse.
REQ-014 SHALL encode state as PAUSE=00, RUN=01, STEP=10, HALTED=11.
REQ-015 PAUSE: synced run_sw=1 -> RUN; else step pulse -> STEP; else stay.
REQ-016 RUN: synced run_sw=0 -> PAUSE; step pulses ignored.
REQ-017 STEP: lasts exactly one cycle; cpu_ce=1 during it; next state is PAUSE.
REQ-018 HALTED: cpu_ce held 0; run_sw, step_btn and div_sel ignored; exit only via rst.
REQ-019 halt_req is sampled only on cycles with cpu_ce=1; if 1, next state is HALTED; this has priority over run_sw=0.
REQ-020 Divider: counter cnt counts only in RUN, 0..N-1 with N=CPU_DIV[div_sel]; cpu_ce=1 on the RUN cycle where cnt=N-1; cnt wraps to 0 on that cycle.
REQ-021 cnt SHALL be cleared on any cycle not in RUN, and on the cycle after registered div_sel differs from its previous value; the first pulse after entry or change comes a full N cycles later.
REQ-022 cpu_ce SHALL never be high on consecutive cycles.
REQ-023 led_ce SHALL free-run independently of state: one-cycle pulse every LED_DIV cycles; the first pulse comes LED_DIV cycles after rst deasserts.
REQ-024 cycle_count SHALL increment by 1 on each cycle with cpu_ce=1 and wrap from 0xFFFFFFFF to 0.
REQ-025 All outputs SHALL be registered.

Reset
REQ-026 While rst=1: state=PAUSE, cpu_ce=0, led_ce=0, cycle_count=0, cnt=0, LED counter=0; synchronizers, debounce counter and debounced level=0; no step pulse pending.
REQ-027 rst SHALL override all inputs on the same edge, including mid-count, in STEP, and in HALTED.

Verification
(Bench overrides: CPU_DIV0=4, CPU_DIV1=6, LED_DIV=3, DB_CYCLES=4.)
REQ-028 Reset: rst high 3 cycles with all inputs toggling -> state=00, cpu_ce=0, led_ce=0, cycle_count=0; then led_ce pulses every 3rd cycle.
REQ-029 Run: div_sel=0, run_sw 0->1 -> state=01 after synchronizer delay; cpu_ce every 4th cycle; after 5 pulses cycle_count=5. Switch div_sel to 1 mid-count -> next pulse 6 cycles after the change, then every 6.
REQ-030 Pause: drop run_sw with cnt=2 -> state=00, no cpu_ce; raise run_sw again -> first cpu_ce a full 4 cycles after RUN entry.
REQ-031 Step: step_btn glitches high for 3 cycles -> no STEP; high for 10 cycles -> exactly one cycle in state 10 with cpu_ce=1, cycle_count+1, back to 00; release -> no pulse.
REQ-032 Halt: halt_req=1 coincident with a cpu_ce in RUN -> state=11 next cycle; run_sw toggles and step presses -> cpu_ce stays 0, cycle_count frozen, led_ce continues; rst -> state=00.
REQ-033 Wrap: force cycle_count=0xFFFFFFFF, issue one step -> cycle_count=0.
